// File: rtl/sym_tx.sv
// sym_tx: baud-rate PAM2 / Gray-PAM4 symbol transmitter with a fractional NCO baud clock.
// Latency: a baud tick in cycle t yields a new y_n with a sym_strobe pulse in cycle t+1.
// Backpressure: user symbols are pulled once per tick through s_ready; a missing symbol sends 0 and sets underrun.
// Ports: clk/rst (async, active-high); en run request; fcw baud control word;
//   pam4/src_user mode bits (latched at start); preemph_en 1-tap pre-emphasis;
//   s_data/s_valid/s_ready user symbol handshake; y_n signed sample; sym_strobe new-symbol pulse;
//   busy (not idle); underrun (sticky missing-symbol flag).
module sym_tx #(
  parameter int PREAMBLE_LEN = 64,
  parameter int AMP_OUT      = 96,
  parameter int AMP_IN       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [31:0]       fcw,
  input  logic              pam4,
  input  logic              src_user,
  input  logic              preemph_en,
  input  logic [1:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic signed [7:0] y_n,
  output logic              sym_strobe,
  output logic              busy,
  output logic              underrun
);

  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam logic signed [7:0] LVL_OP = 8'(AMP_OUT);
  localparam logic signed [7:0] LVL_ON = 8'(-AMP_OUT);
  localparam logic signed [7:0] LVL_IP = 8'(AMP_IN);
  localparam logic signed [7:0] LVL_IN = 8'(-AMP_IN);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

  state_t            state, state_nx;
  logic [31:0]       phase;
  logic [32:0]       phase_sum;
  logic [CW-1:0]     cnt;
  logic [6:0]        prbs;
  logic [6:0]        prbs_1, prbs_2;
  logic              bit_1, bit_2;
  logic              pam4_q, user_q;
  logic signed [7:0] lprev;
  logic signed [7:0] lprev_sh;
  logic signed [7:0] level;
  logic signed [9:0] pe_raw;
  logic signed [7:0] y_sym;
  logic [1:0]        bits;
  logic              tick, emit, stop_now;

  // Carry out of the phase accumulator is the baud tick.
  assign phase_sum = {1'b0, phase} + {1'b0, fcw};
  assign tick      = (state != IDLE) && phase_sum[32];
  assign emit      = tick && en;
  // With fcw=0 no tick would ever come, so a stop request takes effect at once.
  assign stop_now  = (state != IDLE) && !en && (tick || (fcw == 32'd0));
  // en low on a tick ends the run, so no symbol is taken on that tick.
  assign s_ready   = emit && (state == PAYLOAD) && user_q;
  assign busy      = (state != IDLE);

  // Two PRBS7 steps; PAM2 uses only the first, PAM4 takes msb first.
  assign bit_1  = prbs[6] ^ prbs[5];
  assign prbs_1 = {prbs[5:0], bit_1};
  assign bit_2  = prbs_1[6] ^ prbs_1[5];
  assign prbs_2 = {prbs_1[5:0], bit_2};

  always_comb begin
    state_nx = state;
    level    = 8'sd0;
    bits     = 2'b00;
    case (state)
      IDLE: if (en) state_nx = PREAMBLE;
      PREAMBLE: begin
        level = cnt[0] ? LVL_ON : LVL_OP;
        if (stop_now) state_nx = IDLE;
        else if (emit && (cnt == CW'(PREAMBLE_LEN - 1))) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (user_q)      bits = s_data;
        else if (pam4_q) bits = {bit_1, bit_2};
        else             bits = {1'b0, bit_1};
        if (pam4_q) begin
          case (bits)
            2'b00:   level = LVL_ON;
            2'b01:   level = LVL_IN;
            2'b11:   level = LVL_IP;
            default: level = LVL_OP;
          endcase
        end else begin
          level = bits[0] ? LVL_OP : LVL_ON;
        end
        if (user_q && !s_valid) level = 8'sd0;
        if (stop_now) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // 1-tap pre-emphasis, widened so the subtraction cannot wrap before saturation.
  assign lprev_sh = lprev >>> 2;
  assign pe_raw   = $signed({{2{level[7]}}, level}) - $signed({{2{lprev_sh[7]}}, lprev_sh});

  always_comb begin
    y_sym = level;
    if (preemph_en) begin
      if (pe_raw > 10'sd127)       y_sym = 8'sd127;
      else if (pe_raw < -10'sd128) y_sym = -8'sd128;
      else                         y_sym = pe_raw[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      cnt        <= '0;
      prbs       <= 7'h7F;
      pam4_q     <= 1'b0;
      user_q     <= 1'b0;
      lprev      <= '0;
      y_n        <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      sym_strobe <= 1'b0;
      if (state == IDLE) begin
        phase <= '0;
        y_n   <= '0;
        lprev <= '0;
        if (en) begin
          cnt      <= '0;
          prbs     <= 7'h7F;
          pam4_q   <= pam4;
          user_q   <= src_user;
          underrun <= 1'b0;
        end
      end else if (stop_now) begin
        phase <= '0;
        y_n   <= '0;
        lprev <= '0;
      end else begin
        phase <= phase_sum[31:0];
        if (emit) begin
          y_n        <= y_sym;
          sym_strobe <= 1'b1;
          lprev      <= level;
          if (state == PREAMBLE) cnt <= cnt + CW'(1);
          if (state == PAYLOAD) begin
            if (!user_q)       prbs     <= pam4_q ? prbs_2 : prbs_1;
            else if (!s_valid) underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule
